// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the regfile write port between pipeline writeback and a long-latency FIFO
// Ports: clk, reset_n (async active-low); a_* pipeline writeback (always wins, never stalls);
//    b_valid/b_ready/b_addr/b_data long-latency results into a DEPTH-entry FIFO;
//    iss_valid/iss_rd long-latency issue; qry_*/busy_* decode hazard lookups;
//    pipe_stall when the FIFO head has waited STARVE_LIMIT cycles; we3/wa3/wd3 regfile write port.
// Build option REGFILE_SCOREBOARD_EN adds the pending-write scoreboard; without it busy_* are tied 0.
module regfile_wb_arbiter #(
   parameter int DEPTH = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        a_valid,
   input  logic [4:0]  a_addr,
   input  logic [63:0] a_data,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [4:0]  b_addr,
   input  logic [63:0] b_data,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rd,
   input  logic [4:0]  qry_ra1,
   input  logic [4:0]  qry_ra2,
   input  logic [4:0]  qry_rd,
   output logic        busy_ra1,
   output logic        busy_ra2,
   output logic        busy_rd,
   output logic        pipe_stall,
   output logic        we3,
   output logic [4:0]  wa3,
   output logic [63:0] wd3
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   logic [68:0]   mem [DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [CW-1:0] cnt;
   logic          src_b, full, empty, push, pop;
   logic [4:0]    head_addr;
   logic [63:0]   head_data;
   // extra pointer bit distinguishes full from empty when the indices match
   assign empty = wptr == rptr;
   assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign push = b_valid && !full;
   assign pop = !a_valid && !empty;
   assign {head_addr, head_data} = mem[rptr[AW-1:0]];
   assign b_ready = !full;
   assign pipe_stall = cnt == CW'(STARVE_LIMIT);
   always_ff @(posedge clk)
      if (push) mem[wptr[AW-1:0]] <= {b_addr, b_data};
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wptr  <= '0;
         rptr  <= '0;
         cnt   <= '0;
         we3   <= 1'b0;
         wa3   <= '0;
         wd3   <= '0;
         src_b <= 1'b0;
      end else begin
         wptr  <= wptr + PW'(push);
         rptr  <= rptr + PW'(pop);
         cnt   <= (empty || pop) ? '0 : pipe_stall ? cnt : cnt + CW'(1);
         // register 31 is hardwired zero: FIFO entries to it are popped but never written
         we3   <= a_valid ? a_addr != 5'd31 : pop && head_addr != 5'd31;
         src_b <= !a_valid;
         if (a_valid || pop) begin
            wa3 <= a_valid ? a_addr : head_addr;
            wd3 <= a_valid ? a_data : head_data;
         end
      end
`ifdef REGFILE_SCOREBOARD_EN
   logic [31:0] pend, pend_set, pend_clr;
   assign pend_set = (iss_valid && iss_rd != 5'd31) ? 32'd1 << iss_rd : 32'd0;
   assign pend_clr = (we3 && src_b) ? 32'd1 << wa3 : 32'd0;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) pend <= '0;
      else pend <= ((pend & ~pend_clr) | pend_set) & 32'h7fff_ffff;
   assign busy_ra1 = pend[qry_ra1];
   assign busy_ra2 = pend[qry_ra2];
   assign busy_rd  = pend[qry_rd];
`else
   logic unused_sb;
   assign unused_sb = ^{iss_valid, iss_rd, qry_ra1, qry_ra2, qry_rd, src_b};
   assign busy_ra1 = 1'b0;
   assign busy_ra2 = 1'b0;
   assign busy_rd  = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: randomized scoreboard bench for regfile_wb_arbiter against a queue-based model
module tb_regfile_wb_arbiter;
   localparam int DEPTH = 4;
   localparam int LIMIT = 8;
`ifdef REGFILE_SCOREBOARD_EN
   localparam bit SB = 1'b1;
`else
   localparam bit SB = 1'b0;
`endif
   logic clk = 1'b0, reset_n = 1'b0;
   logic a_valid = 0, b_valid = 0, iss_valid = 0;
   logic [4:0] a_addr = 0, b_addr = 0, iss_rd = 0, qry_ra1 = 0, qry_ra2 = 0, qry_rd = 0;
   logic [63:0] a_data = 0, b_data = 0;
   logic b_ready, busy_ra1, busy_ra2, busy_rd, pipe_stall, we3;
   logic [4:0] wa3;
   logic [63:0] wd3;
   regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .qry_ra1(qry_ra1), .qry_ra2(qry_ra2), .qry_rd(qry_rd),
      .busy_ra1(busy_ra1), .busy_ra2(busy_ra2), .busy_rd(busy_rd),
      .pipe_stall(pipe_stall), .we3(we3), .wa3(wa3), .wd3(wd3)
   );
   always #5 clk = ~clk;
   typedef struct {logic [4:0] a; logic [63:0] d;} wr_t;
   wr_t fq[$];
   wr_t exp_q[$];
   wr_t m_e;
   bit pend[32];
   int cnt = 0;
   int clr_cur = 32;
   int tests = 0, fails = 0;
   task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask
   always @(negedge clk)
      if (reset_n && we3) begin
         if (exp_q.size() == 0) chk("unexpected_write", {59'd0, wa3}, 64'd99);
         else begin
            m_e = exp_q.pop_front();
            chk("wa3", {59'd0, wa3}, {59'd0, m_e.a});
            chk("wd3", wd3, m_e.d);
         end
      end
   task automatic model_clear();
      fq.delete();
      exp_q.delete();
      foreach (pend[i]) pend[i] = 0;
      cnt = 0;
      clr_cur = 32;
   endtask
   task automatic step();
      wr_t e;
      bit can_push, nonempty, popped;
      int clr_next;
      clr_next = 32;
      #3;
      chk("b_ready", {63'd0, b_ready}, {63'd0, fq.size() < DEPTH});
      chk("pipe_stall", {63'd0, pipe_stall}, {63'd0, cnt == LIMIT});
      chk("busy_ra1", {63'd0, busy_ra1}, {63'd0, SB && pend[qry_ra1]});
      chk("busy_ra2", {63'd0, busy_ra2}, {63'd0, SB && pend[qry_ra2]});
      chk("busy_rd", {63'd0, busy_rd}, {63'd0, SB && pend[qry_rd]});
      can_push = b_valid && fq.size() < DEPTH;
      nonempty = fq.size() > 0;
      popped = !a_valid && nonempty;
      if (a_valid) begin
         if (a_addr != 5'd31) exp_q.push_back('{a_addr, a_data});
      end else if (nonempty) begin
         e = fq.pop_front();
         if (e.a != 5'd31) begin
            exp_q.push_back(e);
            clr_next = int'(e.a);
         end
      end
      if (can_push) fq.push_back('{b_addr, b_data});
      if (clr_cur < 32) pend[clr_cur] = 0;
      if (iss_valid && iss_rd != 5'd31) pend[iss_rd] = 1;
      clr_cur = clr_next;
      cnt = (nonempty && !popped) ? (cnt < LIMIT ? cnt + 1 : LIMIT) : 0;
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      a_valid = 0;
      b_valid = 0;
      iss_valid = 0;
   endtask
   task automatic do_reset();
      reset_n = 0;
      a_valid = 1'($urandom);
      b_valid = 1'($urandom);
      iss_valid = 1'($urandom);
      a_addr = 5'($urandom);
      b_addr = 5'($urandom);
      iss_rd = 5'($urandom);
      #1;
      chk("rst_we3", {63'd0, we3}, 64'd0);
      chk("rst_wa3", {59'd0, wa3}, 64'd0);
      chk("rst_wd3", wd3, 64'd0);
      chk("rst_b_ready", {63'd0, b_ready}, 64'd1);
      chk("rst_pipe_stall", {63'd0, pipe_stall}, 64'd0);
      chk("rst_busy", {61'd0, busy_ra1, busy_ra2, busy_rd}, 64'd0);
      model_clear();
      @(posedge clk);
      #1;
      chk("rst_hold_we3", {63'd0, we3}, 64'd0);
      idle();
      reset_n = 1;
      step();
   endtask
   initial begin
      model_clear();
      do_reset();
      // A-only writes, including the zero register
      a_valid = 1; a_addr = 5; a_data = 64'hDEAD; step();
      a_addr = 31; a_data = 64'hBEEF; step();
      idle(); step(); step();
      // scoreboard: issue, long-latency return, clear; then same-edge set beats clear
      for (int k = 0; k < 2; k++) begin
         qry_rd = 7; qry_ra1 = 7; qry_ra2 = 3;
         iss_valid = 1; iss_rd = 7; step();
         iss_valid = 0; b_valid = 1; b_addr = 7; b_data = 64'($urandom); step();
         b_valid = 0; step();
         iss_valid = (k == 1); iss_rd = 7; step();
         iss_valid = 0; step(); step();
      end
      // contention: A hogs the port while the FIFO fills and starves
      for (int i = 0; i < 9; i++) begin
         a_valid = 1; a_addr = 5'($urandom); a_data = 64'($urandom);
         b_valid = i < 5; b_addr = 5'(i + 10); b_data = 64'($urandom);
         step();
      end
      idle();
      repeat (6) step();
      // reset mid-drain with queued entries and pending bits
      for (int i = 0; i < 4; i++) begin
         a_valid = 1; a_addr = 5'($urandom); a_data = 64'($urandom);
         b_valid = 1; b_addr = 5'(i + 1); b_data = 64'($urandom);
         iss_valid = i < 2; iss_rd = 5'(i + 1);
         step();
      end
      idle();
      qry_ra1 = 1; qry_ra2 = 2; qry_rd = 3;
      step();
      do_reset();
      repeat (6) step();
      // randomized traffic with occasional asynchronous resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) do_reset();
         a_valid = (cnt == LIMIT) ? 1'b0 : ($urandom_range(0, 99) < 55);
         a_addr = 5'($urandom); a_data = {32'($urandom), 32'($urandom)};
         b_valid = 1'($urandom);
         b_addr = 5'($urandom); b_data = {32'($urandom), 32'($urandom)};
         iss_valid = $urandom_range(0, 99) < 30; iss_rd = 5'($urandom);
         qry_ra1 = 5'($urandom); qry_ra2 = 5'($urandom); qry_rd = 5'($urandom);
         step();
      end
      idle();
      repeat (10) step();
      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
